// File: rtl/if_cached_if.sv
// Fetch-stage bus between the I-cache, the PC source, if_id and mem_ctrl.
// The slave modport is the cache's view of the bus; the master modport is the view of its environment.
interface if_cached_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] pc_i;
  logic [31:0]       without_prediction_i;
  logic              invalidate_i;
  logic [31:0]       inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic [31:0]       without_prediction_o;
  logic              if_stall;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [31:0]       inst_i;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_done;

  modport slave (
    input  pc_i, without_prediction_i, invalidate_i, inst_i, inst_pc, inst_done,
    output inst_o, pc_o, without_prediction_o, if_stall, inst_req, inst_addr_o
  );

  modport master (
    output pc_i, without_prediction_i, invalidate_i, inst_i, inst_pc, inst_done,
    input  inst_o, pc_o, without_prediction_o, if_stall, inst_req, inst_addr_o
  );
endinterface

// File: rtl/if_cached.sv
// Instruction fetch with a direct-mapped I-cache: same-cycle hits, critical-word-first refill
// with beat forwarding, and whole-cache invalidation.
module if_cached #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input logic        clk,
  input logic        rst,
  if_cached_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - INDEX_BITS - OFF_W - 2;
  localparam int LINES  = 1 << INDEX_BITS;
  localparam int BASE_W = TAG_W + INDEX_BITS;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state_q;
  logic [BASE_W-1:0] base_q;
  logic [OFF_W-1:0]  start_q;
  logic [OFF_W-1:0]  cnt_q;
  logic              poison_q;
  logic [ADDR_W-1:0] inst_addr_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_ram [LINES];

  logic [OFF_W-1:0]      pc_word;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_W-1:0]      pc_tag;
  logic                  hit;
  logic                  bypass;
  logic [31:0]           bank_rd [LINE_WORDS];
  logic [31:0]           hit_data;

  logic [INDEX_BITS-1:0] fill_index;
  logic [OFF_W-1:0]      fill_word_d;
  logic [OFF_W-1:0]      next_word_d;
  logic                  beat_we;
  logic                  last_beat;

  assign pc_word  = bus.pc_i[OFF_W+1:2];
  assign pc_index = bus.pc_i[INDEX_BITS+OFF_W+1:OFF_W+2];
  assign pc_tag   = bus.pc_i[ADDR_W-1:ADDR_W-TAG_W];

  assign hit    = valid_q[pc_index] && (tag_ram[pc_index] == pc_tag);
  assign bypass = bus.inst_done && (bus.inst_pc == bus.pc_i);

  assign fill_index  = base_q[INDEX_BITS-1:0];
  assign fill_word_d = start_q + cnt_q;
  assign next_word_d = fill_word_d + OFF_W'(1);
  assign beat_we     = !rst && (state_q == REFILL) && bus.inst_done;
  assign last_beat   = beat_we && (cnt_q == LAST_BEAT);

  // One bank per word position so a whole line can be read combinationally on a hit.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_bank
    logic [31:0] mem [LINES];

    always_ff @(posedge clk) begin
      if (beat_we && (fill_word_d == OFF_W'(gi))) begin
        mem[fill_index] <= bus.inst_i;
      end
    end

    assign bank_rd[gi] = mem[pc_index];
  end

  assign hit_data = bank_rd[pc_word];

  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_ram[fill_index] <= base_q[BASE_W-1:INDEX_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      inst_addr_q <= '0;
      cnt_q       <= '0;
      start_q     <= '0;
      base_q      <= '0;
      poison_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit && !bus.invalidate_i) begin
            base_q      <= {pc_tag, pc_index};
            start_q     <= pc_word;
            cnt_q       <= '0;
            poison_q    <= 1'b0;
            inst_addr_q <= {pc_tag, pc_index, pc_word, 2'b00};
            // The old line is overwritten beat by beat, so its tag must stop matching now.
            valid_q[pc_index] <= 1'b0;
            state_q     <= REFILL;
          end
        end
        REFILL: begin
          if (bus.invalidate_i) begin
            poison_q <= 1'b1;
          end
          if (bus.inst_done) begin
            cnt_q       <= cnt_q + OFF_W'(1);
            inst_addr_q <= {base_q, next_word_d, 2'b00};
            if (cnt_q == LAST_BEAT) begin
              if (!poison_q) begin
                valid_q[fill_index] <= 1'b1;
              end
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // Placed last so it overrides a line completing in the same cycle.
      if (bus.invalidate_i) begin
        valid_q <= '0;
      end
    end
  end

  always_comb begin
    bus.inst_o               = '0;
    bus.pc_o                 = '0;
    bus.without_prediction_o = '0;
    bus.if_stall             = 1'b0;
    bus.inst_req             = 1'b0;
    bus.inst_addr_o          = '0;
    if (!rst) begin
      bus.inst_addr_o = inst_addr_q;
      bus.inst_req    = (state_q == REFILL) && !bus.inst_done;
      if (hit) begin
        bus.inst_o               = hit_data;
        bus.pc_o                 = bus.pc_i;
        bus.without_prediction_o = bus.without_prediction_i;
      end else if (bypass) begin
        bus.inst_o               = bus.inst_i;
        bus.pc_o                 = bus.pc_i;
        bus.without_prediction_o = bus.without_prediction_i;
      end else begin
        bus.if_stall = 1'b1;
      end
    end
  end
endmodule
